// File: rtl/bitwise_arb_pkg.sv
// rtl/bitwise_arb_pkg.sv - opcode, FSM state and width constants for bitwise_unit_arbiter
package bitwise_arb_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_NAND = 2'b10;
    localparam logic [OP_W-1:0] OP_NOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_gates.sv
// rtl/bitwise_gates.sv - WIDTH-bit AND/OR/NAND/NOR gate modules shared by the arbiter
module bitwise_and #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

module bitwise_or #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i | b_i;
endmodule

module bitwise_nand #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module bitwise_nor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = ~(a_i | b_i);
endmodule

// File: rtl/bitwise_unit_arbiter_rr_arbiter.sv
// rtl/bitwise_unit_arbiter_rr_arbiter.sv - combinational round-robin arbiter, search from ptr upward with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);
    logic found;
    int   idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        if (enable_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_i) + k) % NUM_REQ;
                if (!found && req_i[idx]) begin
                    found       = 1'b1;
                    gnt_o[idx]  = 1'b1;
                    gnt_idx_o   = ID_W'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/bitwise_unit_arbiter.sv
// rtl/bitwise_unit_arbiter.sv - round-robin shared bitwise unit; BITWISE_ARB_STATS_EN adds op_count
module bitwise_unit_arbiter
    import bitwise_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef BITWISE_ARB_STATS_EN
   ,output logic [15:0]              op_count
`endif
);
    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               arb_en;
    logic [WIDTH-1:0]   and_y, or_y, nand_y, nor_y, gate_res;

    // No grant while rst is sampled so a reset cycle never looks like an accept.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .enable_i  (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    bitwise_and  #(.WIDTH(WIDTH)) u_and  (.a_i(a_q), .b_i(b_q), .y_o(and_y));
    bitwise_or   #(.WIDTH(WIDTH)) u_or   (.a_i(a_q), .b_i(b_q), .y_o(or_y));
    bitwise_nand #(.WIDTH(WIDTH)) u_nand (.a_i(a_q), .b_i(b_q), .y_o(nand_y));
    bitwise_nor  #(.WIDTH(WIDTH)) u_nor  (.a_i(a_q), .b_i(b_q), .y_o(nor_y));

    always_comb begin
        gate_res = and_y;
        case (op_q)
            OP_AND:  gate_res = and_y;
            OP_OR:   gate_res = or_y;
            OP_NAND: gate_res = nand_y;
            OP_NOR:  gate_res = nor_y;
            default: gate_res = and_y;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        req_ready  = gnt;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_d    = req_op[2*int'(gnt_idx) +: 2];
                    a_d     = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
                    b_d     = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
                    id_d    = gnt_idx;
                    ptr_d   = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = gate_res;
                rsp_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef BITWISE_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == ST_RESP && rsp_ready && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// tb/tb_bitwise_unit_arbiter.sv - directed self-checking bench for bitwise_unit_arbiter
module tb_bitwise_unit_arbiter;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
`ifdef BITWISE_ARB_STATS_EN
    logic [15:0]              op_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    bitwise_unit_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef BITWISE_ARB_STATS_EN
       ,.op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*id +: 2]        = op;
        req_a[WIDTH*id +: WIDTH] = a;
        req_b[WIDTH*id +: WIDTH] = b;
    endtask

    // Starts just after a negedge with the DUT in IDLE and rsp_ready=1.
    task automatic single(input int id, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        chk("single_exec_valid", 32'(rsp_valid), 32'd0);
        chk("single_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_data", 32'(rsp_data), 32'(exp));
        chk("single_rsp_id", 32'(rsp_id), 32'(id));
        @(negedge clk);
        chk("single_idle_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_ready", 32'(req_ready), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        single(2, 2'b00, 8'hCC, 8'hAA, 8'h88);
        single(2, 2'b01, 8'hCC, 8'hAA, 8'hEE);
        single(2, 2'b10, 8'hCC, 8'hAA, 8'h77);
        single(2, 2'b11, 8'hCC, 8'hAA, 8'h11);

        // Round-robin with every requester continuously valid.
        do_reset();
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        set_req(1, 2'b01, 8'h0F, 8'h30);
        set_req(2, 2'b10, 8'hFF, 8'h0F);
        set_req(3, 2'b11, 8'hF0, 8'h0F);
        req_valid = 4'b1111;
        begin
            logic [7:0] rr_exp [4];
            rr_exp[0] = 8'h30;
            rr_exp[1] = 8'h3F;
            rr_exp[2] = 8'hF0;
            rr_exp[3] = 8'h00;
            for (int g = 0; g < 5; g++) begin
                #1;
                chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
                @(negedge clk);
                chk("rr_exec_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
                chk("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[g % 4]));
                @(negedge clk);
            end
        end

        // Backpressure on grant 1.
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h3F);
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp_last_hold_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        chk("bp_released_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("bp_after_data", 32'(rsp_data), 32'hF0);
        chk("bp_after_id", 32'(rsp_id), 32'd2);
        @(negedge clk);

        // Reset in EXEC discards the in-flight result and rewinds the pointer.
        set_req(1, 2'b00, 8'hFF, 8'h00);
        req_valid = 4'b0010;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_no_rsp0", 32'(rsp_valid), 32'd0);
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        req_valid = 4'b1001;
        #1;
        chk("mid_ptr_zero_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        chk("mid_no_rsp1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rsp_data", 32'(rsp_data), 32'h30);
        @(negedge clk);

`ifdef BITWISE_ARB_STATS_EN
        do_reset();
        chk("stats_reset", 32'(op_count), 32'd0);
        single(1, 2'b00, 8'h0F, 8'hFF, 8'h0F);
        single(3, 2'b01, 8'h01, 8'h02, 8'h03);
        single(0, 2'b11, 8'h00, 8'h00, 8'hFF);
        chk("stats_three", 32'(op_count), 32'd3);
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        single(2, 2'b10, 8'hFF, 8'hFF, 8'h00);
        chk("stats_saturate", 32'(op_count), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bitwise_unit_arbiter.md
Name: bitwise_unit_arbiter

Overview:
Shares one bitwise logic unit (AND/OR/NAND/NOR, WIDTH bits) between NUM_REQ requesters. Each requester issues an operation via a valid/ready handshake. A round-robin arbiter grants one requester at a time. A 3-state FSM captures the operands, registers the result and returns it on a single shared response port tagged with the requester ID. It sits between the requesting blocks and the existing bitwise_and/or/nand/nor gate modules, which it instantiates.

Parameters:
WIDTH, 8, operand/result width in bits
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_op  in  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]
req_a  in  WIDTH*NUM_REQ  per-requester operand A, slice i = [WIDTH*i+:WIDTH]
req_b  in  WIDTH*NUM_REQ  per-requester operand B, same slicing
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  WIDTH  operation result
rsp_id  out  ID_W  index of requester that issued the operation

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high; all state updates on the rising edge of clk.
- Opcodes: 2'b00 AND, 2'b01 OR, 2'b10 NAND, 2'b11 NOR.
- Reset values: state=IDLE, rr pointer=0 (requester 0 highest priority), rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, captured op/operands=0.
- FSM states:
  - IDLE: if any req_valid, grant the first valid requester found searching from the pointer upward with wrap-around. req_ready[g]=1 combinationally in this cycle only. Capture op, a, b and id=g. Pointer <= (g+1) mod NUM_REQ. Next state EXEC. With no req_valid, stay in IDLE with req_ready=0.
  - EXEC: rsp_data <= gate result of the captured operands; rsp_id <= captured id; next state RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready=1, then go to IDLE with rsp_valid=0 next cycle.
- req_ready is 0 in EXEC and RESP. At most one req_ready bit is high in any cycle.
- Latency: accept in cycle N; rsp_valid first high in cycle N+2. Minimum issue interval is 3 cycles, since there is no accept in the RESP->IDLE cycle.
- Requests not granted are not dropped. The requester must hold valid, op and operands until its req_ready. A requester that deasserts valid before grant is simply skipped.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Pointer wrap-around: a grant to NUM_REQ-1 sets the pointer to 0.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded. rsp_valid drops in the cycle after rst is sampled, and the pointer returns to 0.
- Opcode decode is purely combinational on the captured op. Result width is exactly WIDTH; there is no carry or extension.

Optional Feature:
Macro BITWISE_ARB_STATS_EN.
- Defined: adds output port op_count [15:0]. It increments by 1 on each completed response handshake (RESP && rsp_ready), saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: the port and counter are absent, and the behaviour is otherwise identical.

Decomposition:
- Package bitwise_arb_pkg holds:
  - the opcode constants (OP_AND, OP_OR, OP_NAND, OP_NOR);
  - the FSM state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2);
  - the op width constant OP_W=2.
- Sub-module rr_arbiter (parameter NUM_REQ) has inputs req, ptr and enable, and outputs a one-hot grant plus the encoded grant index. It is purely combinational.
- The top level holds the FSM, pointer, capture registers and gate instances.

Test Plan:
- Reset check: assert rst for 2 cycles. All outputs are 0 and the FSM is in IDLE; no req_ready while req_valid=0.
- Single request: requester 2 sends op=00, a=8'hCC, b=8'hAA. req_ready[2] pulses 1 cycle; 2 cycles later rsp_valid=1 with rsp_data=8'h88 and rsp_id=2. Repeat with ops 01/10/11 -> 8'hEE/8'h77/8'h11.
- Round-robin: all 4 requesters valid continuously with distinct operands. Grant order is 0,1,2,3,0 and each rsp_id matches its own operand result (e.g. NOR of 8'hF0,8'h0F -> 8'h00).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_data and rsp_id stay stable and no req_ready is asserted. Release, and the next grant occurs in the IDLE cycle after the handshake.
- Reset mid-operation: assert rst in EXEC after accepting a=8'hFF, b=8'h00. No response appears, the pointer returns to 0, and the next simultaneous req 0 and 3 grants 0 first.
- BITWISE_ARB_STATS_EN build: 3 completed responses -> op_count=3. Force op_count to 16'hFFFF, complete 1 more, and it stays at 16'hFFFF.
